// File: rtl/inst_fetch_sram_like.sv
// Instruction-side sram-like fetch master: one outstanding single-word read,
// holds the fetched word with its PC until decode consumes it; flush-aware.
module inst_fetch_sram_like (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] req_pc,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        flush,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_rdata,
    output logic        inst_adel,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata_bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0] state;
    logic       cancel;
    logic       accept;
    logic       misaligned;

    assign req_ready  = ~flush & ((state == IDLE) | ((state == HOLD) & inst_ready));
    assign accept     = req_valid & req_ready;
    assign misaligned = |req_pc[1:0];

    assign inst_req   = (state == ADDR);
    assign inst_valid = (state == HOLD);
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            inst_addr  <= '0;
            inst_pc    <= '0;
            inst_rdata <= '0;
            inst_adel  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                // The request stays up until addr_ok even when flushed; the
                // response is then discarded through cancel.
                ADDR: begin
                    if (flush)
                        cancel <= 1'b1;
                    if (inst_addr_ok)
                        state <= DATA;
                end
                DATA: begin
                    if (inst_data_ok) begin
                        if (!cancel && !flush) begin
                            inst_rdata <= inst_rdata_bus;
                            inst_adel  <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                        cancel <= 1'b0;
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || inst_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Accept is only possible from IDLE or a consumed HOLD, so it
            // overrides the transition chosen above.
            if (accept) begin
                inst_pc <= req_pc;
                if (misaligned) begin
                    inst_rdata <= '0;
                    inst_adel  <= 1'b1;
                    state      <= HOLD;
                end else begin
                    inst_addr <= req_pc;
                    state     <= ADDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_sram_like.sv
// Scoreboard bench for inst_fetch_sram_like: randomised slave latencies and
// fetch/flush/backpressure traffic checked against a transaction-level model.
module tb_inst_fetch_sram_like;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] req_pc = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_rdata;
    logic        inst_adel;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata_bus = '0;

    inst_fetch_sram_like dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_pc         (req_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .flush          (flush),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_rdata     (inst_rdata),
        .inst_adel      (inst_adel),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata_bus (inst_rdata_bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        adel;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Fetch-model state: a bus transaction in flight, and whether it was flushed.
    bit          m_txn = 1'b0;
    bit          m_addr_done = 1'b0;
    bit          m_cancel = 1'b0;
    logic [31:0] m_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_ready();
        return !flush && ((!m_txn && sb_q.size() == 0) || (sb_q.size() != 0 && inst_ready));
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_txn = 1'b0;
        m_addr_done = 1'b0;
        m_cancel = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        acc = req_valid && model_ready();
        if (flush || (sb_q.size() != 0 && inst_ready))
            sb_q.delete();
        if (m_txn) begin
            if (!m_addr_done) begin
                if (inst_addr_ok)
                    m_addr_done = 1'b1;
            end else if (inst_data_ok) begin
                if (!m_cancel && !flush)
                    sb_q.push_back('{pc: m_pc, data: mem_word(m_pc), adel: 1'b0});
                m_txn = 1'b0;
            end
            if (flush && m_txn)
                m_cancel = 1'b1;
            if (!m_txn)
                m_cancel = 1'b0;
        end
        if (acc) begin
            if (req_pc[1:0] != 2'b00) begin
                sb_q.push_back('{pc: req_pc, data: 32'h0, adel: 1'b1});
            end else begin
                m_txn = 1'b1;
                m_addr_done = 1'b0;
                m_cancel = 1'b0;
                m_pc = req_pc;
            end
        end
    endtask

    // Model advances just before each rising edge; async reset clears it at once.
    initial begin
        forever begin
            @(negedge clk or negedge resetn);
            if (!resetn) begin
                model_reset();
            end else begin
                #4;
                if (resetn)
                    model_step();
            end
        end
    end

    // Monitor: mid-cycle comparison of DUT outputs against the model/scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            check("inst_valid", inst_valid, sb_q.size() != 0);
            if (inst_valid && sb_q.size() != 0) begin
                check("inst_pc", inst_pc, sb_q[0].pc);
                check("inst_rdata", inst_rdata, sb_q[0].data);
                check("inst_adel", inst_adel, sb_q[0].adel);
            end
            check("inst_req", inst_req, m_txn && !m_addr_done);
            if (inst_req && m_txn)
                check("inst_addr", inst_addr, m_pc);
            check("req_ready", req_ready, model_ready());
        end
    end

    // Slave: configurable latency (negative = random 0..3), data is a function of address.
    int          a_cfg = 0;
    int          d_cfg = 0;
    logic [31:0] sl_q[$];
    int          a_cnt = 0;
    int          d_cnt = 0;
    bit          a_armed = 1'b0;
    bit          req_was = 1'b0;

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (inst_addr_ok && req_was) begin
                sl_q.push_back(inst_addr);
                d_cnt = pick(d_cfg);
            end
            if (inst_data_ok && sl_q.size() != 0)
                void'(sl_q.pop_front());
            inst_addr_ok = 1'b0;
            if (inst_req) begin
                if (!a_armed) begin
                    a_armed = 1'b1;
                    a_cnt = pick(a_cfg);
                end
                if (a_cnt == 0) begin
                    inst_addr_ok = 1'b1;
                    a_armed = 1'b0;
                end else begin
                    a_cnt--;
                end
            end
            req_was = inst_req;
            inst_data_ok = 1'b0;
            inst_rdata_bus = $urandom;
            if (sl_q.size() != 0) begin
                if (d_cnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata_bus = mem_word(sl_q[0]);
                end else begin
                    d_cnt--;
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] pc, input bit fl, input bit rdy);
        @(posedge clk);
        #1;
        req_valid = v;
        req_pc = pc;
        flush = fl;
        inst_ready = rdy;
    endtask

    initial begin
        logic [31:0] pc;
        #22 resetn = 1'b1;
        check("inst_wr", inst_wr, 32'h0);
        check("inst_size", inst_size, 32'h2);
        check("inst_wdata", inst_wdata, 32'h0);

        // Zero-wait aligned fetch.
        a_cfg = 0; d_cfg = 0;
        cyc(1'b1, 32'hBFC0_0000, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Wait states on both phases.
        a_cfg = 3; d_cfg = 2;
        cyc(1'b1, 32'hBFC0_0004, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush in DATA, one cycle before data_ok; then a fresh fetch.
        a_cfg = 0; d_cfg = 3;
        cyc(1'b1, 32'hBFC0_0100, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'hBFC0_0380, 1'b0, 1'b1);
        repeat (8) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush while the address phase is still waiting.
        a_cfg = 3; d_cfg = 1;
        cyc(1'b1, 32'hBFC0_0200, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (10) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Misaligned fetch.
        cyc(1'b1, 32'h8000_0002, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Backpressure: word held while decode stalls, new request refused.
        a_cfg = 1; d_cfg = 1;
        cyc(1'b1, 32'hBFC0_0400, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 32'hBFC0_0500, 1'b0, 1'b0);
        cyc(1'b1, 32'hBFC0_0500, 1'b0, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Async reset in DATA; the late data_ok must be ignored.
        a_cfg = 0; d_cfg = 6;
        cyc(1'b1, 32'hBFC0_0600, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_inst_req", inst_req, 32'h0);
        check("rst_inst_valid", inst_valid, 32'h0);
        check("rst_inst_addr", inst_addr, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_rdata", inst_rdata, 32'h0);
        check("rst_inst_adel", inst_adel, 32'h0);
        @(negedge clk);
        #3 resetn = 1'b1;
        repeat (10) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic with random slave latencies.
        a_cfg = -1; d_cfg = -1;
        repeat (1500) begin
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0)
                pc[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 9) < 7, pc, $urandom_range(0, 15) == 0,
                $urandom_range(0, 9) < 7);
        end
        repeat (20) cyc(1'b0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
